// File: rtl/conv_mac_seq.sv
// rtl/conv_mac_seq.sv - time-shared 8x8 MAC computing a 4-lane causal truncated 1-D convolution
// Ten MAC cycles per operation: lane k takes k+1 terms, acc is cleared between lanes.
module conv_mac_seq #(
  parameter int SHIFT  = 0,
  parameter bit SAT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        busy,
  output logic        done,
  output logic [31:0] conv_res
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic signed [17:0] acc_q, acc_d;
  logic [1:0]         k_q, k_d;
  logic [1:0]         i_q, i_d;
  logic [23:0]        stage_q, stage_d;
  logic [31:0]        res_q, res_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [1:0]         j;
  logic signed [7:0]  a_lane;
  logic signed [7:0]  b_lane;
  logic signed [15:0] prod;
  logic signed [17:0] acc_sum;
  logic [7:0]         lane_out;

  // Scale then narrow; both saturated and wrapped forms are built so every bit of t is consumed.
  function automatic logic [7:0] narrow(input logic signed [17:0] acc);
    logic signed [17:0] t;
    logic [7:0]         sat;
    t = acc >>> SHIFT;
    if (t > 18'sd127)
      sat = 8'h7F;
    else if (t < -18'sd128)
      sat = 8'h80;
    else
      sat = t[7:0];
    return SAT_EN ? sat : t[7:0];
  endfunction

  always_comb begin
    j        = k_q - i_q;
    a_lane   = a_q[{i_q, 3'b000} +: 8];
    b_lane   = b_q[{j, 3'b000} +: 8];
    prod     = a_lane * b_lane;
    acc_sum  = acc_q + {{2{prod[15]}}, prod};
    lane_out = narrow(acc_sum);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    k_d     = k_q;
    i_d     = i_q;
    stage_d = stage_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (flush) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_d     = in1;
            b_d     = in2;
            acc_d   = '0;
            k_d     = 2'd0;
            i_d     = 2'd0;
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          if (i_q != k_q) begin
            acc_d = acc_sum;
            i_d   = i_q + 2'd1;
          end else begin
            acc_d = '0;
            i_d   = 2'd0;
            if (k_q == 2'd3) begin
              res_d   = {lane_out, stage_q};
              done_d  = 1'b1;
              busy_d  = 1'b0;
              k_d     = 2'd0;
              state_d = IDLE;
            end else begin
              case (k_q)
                2'd0:    stage_d[7:0]   = lane_out;
                2'd1:    stage_d[15:8]  = lane_out;
                default: stage_d[23:16] = lane_out;
              endcase
              k_d = k_q + 2'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      i_q     <= '0;
      stage_q <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      i_q     <= i_d;
      stage_q <= stage_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign conv_res = res_q;

endmodule
